// File: rtl/contador_plazas.sv
// Parking-lot occupancy counter: edge-detects entry/exit pulses from the direction
// detector, tracks occupied spaces and presents free spaces as two BCD digits.
module contador_plazas #(
  parameter int CAPACIDAD = 20,
  parameter int W         = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entrada,
  input  logic         salida,
  input  logic         clr_error,
  output logic [W-1:0] ocupados,
  output logic [3:0]   libres_dec,
  output logic [3:0]   libres_uni,
  output logic         lleno,
  output logic         vacio,
  output logic         err_lleno,
  output logic         err_vacio
);

  localparam logic [W-1:0] CAP = W'(CAPACIDAD);

  logic         entrada_prev;
  logic         salida_prev;
  logic         ev_in;
  logic         ev_out;
  logic [W-1:0] ocupados_next;
  logic         set_lleno;
  logic         set_vacio;
  logic [W-1:0] libres;
  logic [6:0]   libres7;

  assign ev_in  = entrada & ~entrada_prev;
  assign ev_out = salida  & ~salida_prev;

  assign lleno  = (ocupados == CAP);
  assign vacio  = (ocupados == '0);
  assign libres = CAP - ocupados;

  // A simultaneous entry and exit is a net-zero move, so it never flags an error.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    ocupados_next = ocupados;
    set_lleno     = 1'b0;
    set_vacio     = 1'b0;
    unique case ({ev_in, ev_out})
      2'b10: begin
        if (lleno) set_lleno = 1'b1;
        else       ocupados_next = ocupados + 1'b1;
      end
      2'b01: begin
        if (vacio) set_vacio = 1'b1;
        else       ocupados_next = ocupados - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      ocupados     <= '0;
      entrada_prev <= 1'b0;
      salida_prev  <= 1'b0;
      err_lleno    <= 1'b0;
      err_vacio    <= 1'b0;
    end else begin
      ocupados     <= ocupados_next;
      entrada_prev <= entrada;
      salida_prev  <= salida;
      // A new error in the same cycle as clr_error wins.
      err_lleno    <= set_lleno | (err_lleno & ~clr_error);
      err_vacio    <= set_vacio | (err_vacio & ~clr_error);
    end
  end

  // Tens digit by compare against 10..90; the largest threshold reached is the digit.
  always_comb begin
    libres7    = 7'(libres);
    libres_dec = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (libres7 >= 7'(t * 10)) libres_dec = 4'(t);
    end
    libres_uni = 4'(libres7 - 7'(libres_dec * 4'd10));
  end

  a_cap: assert property (@(posedge clk) disable iff (rst) ocupados <= CAP);

endmodule

// File: tb/tb_contador_plazas.sv
// Self-checking bench for contador_plazas: a behavioural model pushes the expected
// outputs per cycle into a queue, which is popped and compared after each edge.
module tb_contador_plazas;

  localparam int CAPACIDAD = 20;
  localparam int W         = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         entrada;
  logic         salida;
  logic         clr_error;
  logic [W-1:0] ocupados;
  logic [3:0]   libres_dec;
  logic [3:0]   libres_uni;
  logic         lleno;
  logic         vacio;
  logic         err_lleno;
  logic         err_vacio;

  contador_plazas #(.CAPACIDAD(CAPACIDAD), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .entrada   (entrada),
    .salida    (salida),
    .clr_error (clr_error),
    .ocupados  (ocupados),
    .libres_dec(libres_dec),
    .libres_uni(libres_uni),
    .lleno     (lleno),
    .vacio     (vacio),
    .err_lleno (err_lleno),
    .err_vacio (err_vacio)
  );

  always #5 clk = ~clk;

  typedef struct {
    int occ;
    int dec;
    int uni;
    int full;
    int empty;
    int el;
    int ev;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_occ = 0;
  bit m_el = 0, m_ev = 0, m_pe = 0, m_ps = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit e, input bit s, input bit c, input bit r);
    exp_t x;
    bit ei, eo;
    if (r) begin
      m_occ = 0; m_el = 0; m_ev = 0; m_pe = 0; m_ps = 0;
    end else begin
      ei   = e && !m_pe;
      eo   = s && !m_ps;
      m_pe = e;
      m_ps = s;
      if (c) begin m_el = 0; m_ev = 0; end
      if (ei && !eo) begin
        if (m_occ == CAPACIDAD) m_el = 1;
        else m_occ++;
      end
      if (eo && !ei) begin
        if (m_occ == 0) m_ev = 1;
        else m_occ--;
      end
    end
    x.occ   = m_occ;
    x.dec   = (CAPACIDAD - m_occ) / 10;
    x.uni   = (CAPACIDAD - m_occ) % 10;
    x.full  = (m_occ == CAPACIDAD);
    x.empty = (m_occ == 0);
    x.el    = m_el;
    x.ev    = m_ev;
    sb.push_back(x);
  endtask

  task automatic compare_pop();
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    x = sb.pop_front();
    check("ocupados",   int'(ocupados),   x.occ);
    check("libres_dec", int'(libres_dec), x.dec);
    check("libres_uni", int'(libres_uni), x.uni);
    check("lleno",      int'(lleno),      x.full);
    check("vacio",      int'(vacio),      x.empty);
    check("err_lleno",  int'(err_lleno),  x.el);
    check("err_vacio",  int'(err_vacio),  x.ev);
  endtask

  // Drive one cycle of inputs, predict, clock, then compare 1 time unit after the edge.
  task automatic cyc(input bit e, input bit s, input bit c, input bit r);
    entrada   = e;
    salida    = s;
    clr_error = c;
    rst       = r;
    model_step(e, s, c, r);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic pulse_in();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic pulse_out();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    // Reset for two cycles, then idle.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("rst_ocupados", int'(ocupados), 0);
    check("rst_vacio", int'(vacio), 1);
    check("rst_lleno", int'(lleno), 0);
    check("rst_dec", int'(libres_dec), 2);
    check("rst_uni", int'(libres_uni), 0);
    check("rst_errs", int'({err_lleno, err_vacio}), 0);

    // Three spaced pulses: count visible one cycle after each pulse.
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0, 0);
      check("step_ocupados", int'(ocupados), k);
      check("step_uni", int'(libres_uni), 10 - k);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check("step_dec", int'(libres_dec), 1);

    // Held level counts once.
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("hold_ocupados", int'(ocupados), 4);

    // Simultaneous entry and exit.
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("both_ocupados", int'(ocupados), 4);
    check("both_errs", int'({err_lleno, err_vacio}), 0);

    // Fill from reset, then overflow.
    cyc(0, 0, 0, 1);
    repeat (CAPACIDAD) pulse_in();
    check("full_ocupados", int'(ocupados), 20);
    check("full_lleno", int'(lleno), 1);
    check("full_digits", int'({libres_dec, libres_uni}), 0);
    pulse_in();
    check("ovf_ocupados", int'(ocupados), 20);
    check("ovf_err", int'(err_lleno), 1);
    cyc(0, 0, 1, 0);
    check("clr_err_lleno", int'(err_lleno), 0);
    check("clr_ocupados", int'(ocupados), 20);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("both_full_err", int'(err_lleno), 0);
    check("both_full_occ", int'(ocupados), 20);

    // Drain to empty, then underflow.
    repeat (CAPACIDAD) pulse_out();
    check("empty_ocupados", int'(ocupados), 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("both_empty_err", int'(err_vacio), 0);
    pulse_out();
    check("udf_ocupados", int'(ocupados), 0);
    check("udf_err", int'(err_vacio), 1);
    cyc(0, 1, 1, 0);
    check("set_beats_clr", int'(err_vacio), 1);
    cyc(0, 0, 1, 0);
    check("clr_err_vacio", int'(err_vacio), 0);

    // Reset coinciding with an entry pulse.
    repeat (7) pulse_in();
    check("seven", int'(ocupados), 7);
    cyc(1, 0, 0, 1);
    check("rst_pulse_occ", int'(ocupados), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_pulse_dropped", int'(ocupados), 0);

    // Random traffic, scoreboard-checked every cycle.
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
